zclk_turbo_ctrl: RTL and testbench

//  Sequences Z80 clock-rate changes and wait-state stalls for the zclock generator.
//  - Takes the CPU turbo request from the port decoder.
//  - Applies it only at a refresh cycle, holds a short settle stall, and adds optional Pentagon-312 boost.
//  - Schedules DOS/IO stall windows.
//  - Drives zclock's turbo input and a merged stall input.

---
 rtl/zclk_pkg.sv | 21 ++
 rtl/zclk_turbo_ctrl_if.sv | 32 +++
 rtl/zclk_stall_cnt.sv | 44 ++++
 rtl/zclk_turbo_ctrl.sv | 116 +++++++++++
 tb/tb_zclk_turbo_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/zclk_pkg.sv
// Shared definitions for the Z80 clock-rate controller: rate codes,
// rate-FSM states and the rate-equivalence rule.
package zclk_pkg;

  localparam logic [1:0] TURBO_35 = 2'b00;
  localparam logic [1:0] TURBO_7  = 2'b01;
  localparam logic [1:0] TURBO_14 = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PEND,
    ST_WAIT_Z,
    ST_HOLD
  } rate_state_e;

  // Codes 10 and 11 both mean 14MHz; bit0 only matters when bit1 is clear.
  function automatic logic same_rate(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[1] || (a[0] == b[0]));
  endfunction

endpackage

// File: rtl/zclk_turbo_ctrl_if.sv
// Signal bundle between the port decoder / video timing side (master)
// and the clock-rate controller (slave).
interface zclk_turbo_ctrl_if;

  logic       zneg;
  logic       rfsh_n;
  logic [1:0] turbo_req;
  logic       iorq_s;
  logic       external_port;
  logic       dos_on;
  logic       vdos_off;
  logic       boost_start;
  logic [4:0] hcnt;
  logic       upper8;
  logic [1:0] turbo;
  logic       stall;
  logic       t_boost;
  logic       turbo_chg;

  modport master (
    output zneg, rfsh_n, turbo_req, iorq_s, external_port, dos_on, vdos_off,
           boost_start, hcnt, upper8,
    input  turbo, stall, t_boost, turbo_chg
  );

  modport slave (
    input  zneg, rfsh_n, turbo_req, iorq_s, external_port, dos_on, vdos_off,
           boost_start, hcnt, upper8,
    output turbo, stall, t_boost, turbo_chg
  );

endinterface

// File: rtl/zclk_stall_cnt.sv
// DOS/IO wait-state window: asserts in the trigger cycle, then for the
// loaded number of cycles; a retrigger only ever lengthens the window.
module zclk_stall_cnt #(
  parameter int IO_N  = 8,
  parameter int DOS_N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dos_st,
  input  logic io_st,
  output logic dos_io_stall
);

  localparam int MAX_N = (IO_N > DOS_N) ? IO_N : DOS_N;
  localparam int CW    = $clog2(MAX_N) + 1;

  localparam logic [CW-1:0] IO_LEN  = CW'(IO_N);
  localparam logic [CW-1:0] DOS_LEN = CW'(DOS_N);
  localparam logic [CW-1:0] MAX_LEN = CW'(MAX_N);

  logic [CW-1:0] cnt;
  logic [CW-1:0] load_len;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    load_len = DOS_LEN;
    if (io_st && dos_st) load_len = MAX_LEN;
    else if (io_st)      load_len = IO_LEN;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (dos_st || io_st) begin
      cnt <= (cnt > load_len) ? cnt : load_len;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign dos_io_stall = dos_st | io_st | (cnt != '0);

endmodule

// File: rtl/zclk_turbo_ctrl.sv
// Z80 clock-rate sequencer: applies turbo changes at a refresh cycle and
// zneg, stalls while the new rate settles, and runs the Pentagon boost window.
module zclk_turbo_ctrl
  import zclk_pkg::*;
#(
  parameter int DOS_STALL_CYC = 4,
  parameter int IO_STALL_CYC  = 8,
  parameter int SETTLE_CYC    = 2,
  parameter bit BOOST_EN      = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  zclk_turbo_ctrl_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYC + 1) + 1;

  rate_state_e   state;
  logic [1:0]    turbo_eff;
  logic [1:0]    turbo_out;
  logic [SW-1:0] settle_cnt;
  logic          turbo_chg;
  logic          t_boost;
  logic [2:0]    rfsh_sr;
  logic          rfsh_fall;
  logic          dos_st;
  logic          io_st;
  logic          dos_io_stall;

  // NOTE: the synchroniser resets to the idle (high) level so reset release cannot fake a refresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rfsh_sr <= '1;
    else        rfsh_sr <= {rfsh_sr[1:0], bus.rfsh_n};
  end

  assign rfsh_fall = rfsh_sr[2] & ~rfsh_sr[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      turbo_eff  <= TURBO_35;
      settle_cnt <= '0;
      turbo_chg  <= 1'b0;
    end else begin
      turbo_chg <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (!same_rate(bus.turbo_req, turbo_eff)) state <= ST_PEND;
        end
        ST_PEND: begin
          if (same_rate(bus.turbo_req, turbo_eff)) state <= ST_RUN;
          else if (rfsh_fall)                      state <= ST_WAIT_Z;
        end
        ST_WAIT_Z: begin
          // Whatever is requested at this zneg is what gets applied.
          if (bus.zneg) begin
            turbo_eff  <= bus.turbo_req;
            turbo_chg  <= (bus.turbo_req != turbo_eff);
            settle_cnt <= SW'(SETTLE_CYC);
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (settle_cnt <= SW'(1)) begin
            settle_cnt <= '0;
            state      <= ST_RUN;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
      endcase
    end
  end

  generate
    if (BOOST_EN) begin : g_boost
      logic [4:0] hcnt_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          t_boost <= 1'b0;
          hcnt_r  <= '0;
        end else if (bus.boost_start && !t_boost) begin
          t_boost <= 1'b1;
          hcnt_r  <= bus.hcnt;
        end else if (t_boost && !bus.upper8 && (bus.hcnt == hcnt_r)) begin
          t_boost <= 1'b0;
        end
      end
    end else begin : g_no_boost
      assign t_boost = 1'b0;
    end
  endgenerate

  // Boost lifts 3.5MHz to 7MHz without going through the rate FSM.
  assign turbo_out = ((turbo_eff == TURBO_35) && t_boost) ? TURBO_7 : turbo_eff;

  assign dos_st = bus.dos_on | bus.vdos_off;
  assign io_st  = bus.iorq_s & bus.external_port & turbo_out[1];

  zclk_stall_cnt #(
    .IO_N  (IO_STALL_CYC),
    .DOS_N (DOS_STALL_CYC)
  ) u_stall_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .dos_st       (dos_st),
    .io_st        (io_st),
    .dos_io_stall (dos_io_stall)
  );

  assign bus.turbo     = turbo_out;
  assign bus.stall     = dos_io_stall | (state == ST_HOLD);
  assign bus.t_boost   = t_boost;
  assign bus.turbo_chg = turbo_chg;

endmodule

// File: tb/tb_zclk_turbo_ctrl.sv
// Self-checking bench for zclk_turbo_ctrl: directed scenarios plus randomized
// stimulus compared against a rule-level reference model.
module tb_zclk_turbo_ctrl;

  localparam int IO_N  = 8;
  localparam int DOS_N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [1:0] m_turbo;  // model: effective rate the controller should be using

  zclk_turbo_ctrl_if bus ();

  zclk_turbo_ctrl #(
    .DOS_STALL_CYC (DOS_N),
    .IO_STALL_CYC  (IO_N),
    .SETTLE_CYC    (2),
    .BOOST_EN      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit same_speed(input logic [1:0] a, input logic [1:0] b);
    return (a[1] && b[1]) || (a == b);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.zneg          = 1'b0;
    bus.rfsh_n        = 1'b1;
    bus.iorq_s        = 1'b0;
    bus.external_port = 1'b0;
    bus.dos_on        = 1'b0;
    bus.vdos_off      = 1'b0;
    bus.boost_start   = 1'b0;
    bus.hcnt          = 5'd0;
    bus.upper8        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.turbo_req = 2'b00;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    m_turbo = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.turbo_req = 2'b00;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (bus.turbo !== 2'b00) begin failures++; $display("FAIL reset_turbo got=%b exp=00", bus.turbo); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.t_boost !== 1'b0) begin failures++; $display("FAIL reset_tboost got=%b exp=0", bus.t_boost); end
    checks++; if (bus.turbo_chg !== 1'b0) begin failures++; $display("FAIL reset_chg got=%b exp=0", bus.turbo_chg); end
    rst_n = 1'b1;
    m_turbo = 2'b00;
  endtask

  // Request, stray zneg in PEND, refresh pulse, then the zneg that applies it.
  // The new rate shows one clk after that zneg, with a 2-clk settle stall.
  task automatic test_rate_change(input logic [1:0] req);
    logic [1:0] exp_t;
    bus.turbo_req = req;
    for (int c = 0; c < 14; c++) begin
      bus.rfsh_n = !(c == 2 || c == 3);
      bus.zneg   = (c == 1) || (c == 8);
      @(negedge clk);
      exp_t = (c >= 9) ? req : m_turbo;
      checks++; if (bus.turbo !== exp_t) begin failures++; $display("FAIL rate_turbo req=%b c=%0d got=%b exp=%b", req, c, bus.turbo, exp_t); end
      checks++; if (bus.turbo_chg !== (c == 9)) begin failures++; $display("FAIL rate_chg req=%b c=%0d got=%b exp=%b", req, c, bus.turbo_chg, (c == 9)); end
      checks++; if (bus.stall !== (c == 9 || c == 10)) begin failures++; $display("FAIL rate_stall req=%b c=%0d got=%b exp=%b", req, c, bus.stall, (c == 9 || c == 10)); end
      checks++; if (bus.t_boost !== 1'b0) begin failures++; $display("FAIL rate_tboost c=%0d got=%b exp=0", c, bus.t_boost); end
      next_cycle();
    end
    m_turbo = req;
  endtask

  // Request withdrawn before any refresh edge: nothing may change.
  task automatic test_cancel();
    for (int c = 0; c < 20; c++) begin
      bus.turbo_req = (c < 3) ? 2'b01 : 2'b00;
      bus.zneg      = (c % 4 == 1);
      bus.rfsh_n    = !(c == 8 || c == 9);
      @(negedge clk);
      checks++; if (bus.turbo !== 2'b00) begin failures++; $display("FAIL cancel_turbo c=%0d got=%b exp=00", c, bus.turbo); end
      checks++; if (bus.turbo_chg !== 1'b0) begin failures++; $display("FAIL cancel_chg c=%0d got=%b exp=0", c, bus.turbo_chg); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL cancel_stall c=%0d got=%b exp=0", c, bus.stall); end
      next_cycle();
    end
    idle_inputs();
  endtask

  // 11 is the same rate as 10, so it must not start a change.
  task automatic test_rate_alias();
    bus.turbo_req = 2'b11;
    for (int c = 0; c < 15; c++) begin
      bus.rfsh_n = !(c == 2 || c == 3);
      bus.zneg   = (c == 8);
      @(negedge clk);
      checks++; if (bus.turbo !== m_turbo) begin failures++; $display("FAIL alias_turbo c=%0d got=%b exp=%b", c, bus.turbo, m_turbo); end
      checks++; if (bus.turbo_chg !== 1'b0) begin failures++; $display("FAIL alias_chg c=%0d got=%b exp=0", c, bus.turbo_chg); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL alias_stall c=%0d got=%b exp=0", c, bus.stall); end
      next_cycle();
    end
    idle_inputs();
  endtask

  // External IO stalls trigger + IO_N cycles, only at 14MHz; internal IO never.
  task automatic test_io_stall();
    logic exp_s;
    for (int c = 0; c < 22; c++) begin
      bus.iorq_s        = (c == 0) || (c == 14);
      bus.external_port = (c == 0);
      @(negedge clk);
      exp_s = m_turbo[1] && (c <= IO_N);
      checks++; if (bus.stall !== exp_s) begin failures++; $display("FAIL io_stall turbo=%b c=%0d got=%b exp=%b", m_turbo, c, bus.stall, exp_s); end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Overlapping triggers: windows merge, none is cut short.
  task automatic test_retrigger();
    for (int c = 0; c < 16; c++) begin
      bus.iorq_s = (c == 0); bus.external_port = (c == 0); bus.dos_on = (c == 6);
      @(negedge clk);
      checks++; if (bus.stall !== (c <= 10)) begin failures++; $display("FAIL retrig_io_dos c=%0d got=%b exp=%b", c, bus.stall, (c <= 10)); end
      next_cycle();
    end
    for (int c = 0; c < 16; c++) begin
      bus.vdos_off = (c == 0); bus.iorq_s = (c == 2); bus.external_port = (c == 2); bus.dos_on = 1'b0;
      @(negedge clk);
      checks++; if (bus.stall !== (c <= 10)) begin failures++; $display("FAIL retrig_dos_io c=%0d got=%b exp=%b", c, bus.stall, (c <= 10)); end
      next_cycle();
    end
    for (int c = 0; c < 14; c++) begin
      bus.vdos_off = 1'b0; bus.dos_on = (c == 0); bus.iorq_s = (c == 0); bus.external_port = (c == 0);
      @(negedge clk);
      checks++; if (bus.stall !== (c <= IO_N)) begin failures++; $display("FAIL retrig_both c=%0d got=%b exp=%b", c, bus.stall, (c <= IO_N)); end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Random DOS/IO triggers against a "remaining stall cycles" model.
  task automatic test_random_stall();
    int rem = 0;
    int n;
    bit trig_io, trig_dos, exp_s;
    for (int c = 0; c < 320; c++) begin
      bus.dos_on        = (c < 300) && ($urandom_range(0, 15) == 0);
      bus.vdos_off      = (c < 300) && ($urandom_range(0, 23) == 0);
      bus.iorq_s        = (c < 300) && ($urandom_range(0, 5) == 0);
      bus.external_port = $urandom_range(0, 1) == 1;
      trig_io  = bus.iorq_s && bus.external_port && m_turbo[1];
      trig_dos = bus.dos_on || bus.vdos_off;
      n = 0;
      if (trig_dos && DOS_N > n) n = DOS_N;
      if (trig_io && IO_N > n)   n = IO_N;
      exp_s = trig_io || trig_dos || (rem > 0);
      @(negedge clk);
      checks++; if (bus.stall !== exp_s) begin failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b rem=%0d", c, bus.stall, exp_s, rem); end
      if (trig_io || trig_dos) rem = (rem > n) ? rem : n;
      else if (rem > 0)        rem--;
      next_cycle();
    end
    idle_inputs();
  endtask

  // Boost window from 3.5MHz: held while upper8, ends when hcnt returns to its start value.
  task automatic test_boost();
    bit         mb = 1'b0;
    logic [4:0] mcap = 5'd0;
    logic [1:0] exp_t;
    for (int c = 0; c < 200; c++) begin
      bus.hcnt          = 5'(c);
      bus.boost_start   = (c == 5) || (c == 9) || (c >= 80 && $urandom_range(0, 15) == 0);
      bus.upper8        = (c < 50) ? 1'b1 : ((c >= 80) ? ($urandom_range(0, 2) == 0) : 1'b0);
      bus.iorq_s        = $urandom_range(0, 3) == 0;
      bus.external_port = 1'b1;
      exp_t = (m_turbo == 2'b00 && mb) ? 2'b01 : m_turbo;
      @(negedge clk);
      checks++; if (bus.turbo !== exp_t) begin failures++; $display("FAIL boost_turbo c=%0d got=%b exp=%b", c, bus.turbo, exp_t); end
      checks++; if (bus.t_boost !== mb) begin failures++; $display("FAIL boost_flag c=%0d got=%b exp=%b", c, bus.t_boost, mb); end
      checks++; if (bus.turbo_chg !== 1'b0) begin failures++; $display("FAIL boost_chg c=%0d got=%b exp=0", c, bus.turbo_chg); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL boost_stall c=%0d got=%b exp=0", c, bus.stall); end
      if (bus.boost_start && !mb) begin mb = 1'b1; mcap = bus.hcnt; end
      else if (mb && !bus.upper8 && bus.hcnt == mcap) mb = 1'b0;
      next_cycle();
    end
    idle_inputs();
  endtask

  // Reset during the settle stall, request still pending, then re-detection.
  task automatic test_reset_mid();
    bus.turbo_req = 2'b10;
    for (int c = 0; c < 9; c++) begin
      bus.rfsh_n = !(c == 2 || c == 3);
      bus.zneg   = (c == 8);
      next_cycle();
    end
    idle_inputs();
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL midrst_hold_stall got=%b exp=1", bus.stall); end
    checks++; if (bus.turbo !== 2'b10) begin failures++; $display("FAIL midrst_hold_turbo got=%b exp=10", bus.turbo); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.turbo !== 2'b00) begin failures++; $display("FAIL midrst_turbo got=%b exp=00", bus.turbo); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.turbo_chg !== 1'b0) begin failures++; $display("FAIL midrst_chg got=%b exp=0", bus.turbo_chg); end
    next_cycle();
    rst_n = 1'b1;
    m_turbo = 2'b00;
    test_rate_change(2'b10);
  endtask

  task automatic test_random_rates();
    logic [1:0] r;
    for (int i = 0; i < 8; i++) begin
      r = 2'($urandom_range(0, 3));
      while (same_speed(r, m_turbo)) r = 2'($urandom_range(0, 3));
      test_rate_change(r);
    end
  endtask

  initial begin
    test_reset();
    test_cancel();
    test_rate_change(2'b10);
    test_rate_alias();
    test_io_stall();
    test_retrigger();
    test_random_stall();
    test_rate_change(2'b01);
    test_io_stall();
    do_reset();
    test_boost();
    do_reset();
    test_reset_mid();
    test_random_rates();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
